// File: rtl/dispatch_bundle_receiver_pkg.sv
// Shared types for the rename->dispatch bundle receiver.
// Lane packet, per-bundle resource needs, head-state encoding.
package dispatch_bundle_receiver_pkg;

`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

  localparam int DISPATCH_WIDTH    = `DISPATCH_WIDTH;
  localparam int DISPATCH_RX_DEPTH = 2;
  localparam int FREE_CNT_W        = 6;
  localparam int LANE_CNT_W        = $clog2(DISPATCH_WIDTH + 1);
  // Must hold both a lane count and the largest backend free count.
  localparam int CNT_W =
    (LANE_CNT_W > FREE_CNT_W) ? LANE_CNT_W : FREE_CNT_W;

  typedef struct packed {
    logic [31:0] pc;
    logic        SkipIQ;
    logic        isLoad;
    logic        isStore;
    logic        isCSR;
    logic        isFenceI;
    logic        isSret;
    logic        isMret;
  } disPkt;

  typedef struct packed {
    logic [CNT_W-1:0] nIQ;
    logic [CNT_W-1:0] nLd;
    logic [CNT_W-1:0] nSt;
    logic [CNT_W-1:0] nAL;
    logic             ser;
  } bundleNeeds_t;

  typedef enum logic [1:0] {
    HD_IDLE,
    HD_WAIT_RES,
    HD_WAIT_SER,
    HD_SEND
  } head_st_e;

  function automatic logic needs_fit(
    input bundleNeeds_t     n,
    input logic [CNT_W-1:0] iq,
    input logic [CNT_W-1:0] ld,
    input logic [CNT_W-1:0] st,
    input logic [CNT_W-1:0] al
  );
    return (n.nIQ <= iq) && (n.nLd <= ld) &&
           (n.nSt <= st) && (n.nAL <= al);
  endfunction

endpackage

// File: rtl/dispatch_bundle_receiver_if.sv
// Rename-side and dispatch-side bundle handshake of the receiver.
// master = producer/consumer environment, slave = receiver.
interface dispatch_bundle_receiver_if #(
  parameter int WIDTH = dispatch_bundle_receiver_pkg::DISPATCH_WIDTH
);

  logic                                renameReady_i;
  dispatch_bundle_receiver_pkg::disPkt disPacket_i [WIDTH];
  logic [WIDTH-1:0]                    laneActive_i;
  logic                                stall_o;
  logic                                dispatchValid_o;
  dispatch_bundle_receiver_pkg::disPkt disPacket_o [WIDTH];
  logic [WIDTH-1:0]                    laneValid_o;

  modport master (
    output renameReady_i,
    output disPacket_i,
    output laneActive_i,
    input  stall_o,
    input  dispatchValid_o,
    input  disPacket_o,
    input  laneValid_o
  );

  modport slave (
    input  renameReady_i,
    input  disPacket_i,
    input  laneActive_i,
    output stall_o,
    output dispatchValid_o,
    output disPacket_o,
    output laneValid_o
  );

endinterface

// File: rtl/dispatch_bundle_receiver_need_count.sv
// Combinational per-bundle resource need counter.
// Only lanes with their laneActive bit set contribute.
module dispatch_need_count
  import dispatch_bundle_receiver_pkg::*;
#(
  parameter int WIDTH = DISPATCH_WIDTH
) (
  input  disPkt            pkt_i [WIDTH],
  input  logic [WIDTH-1:0] lane_i,
  output bundleNeeds_t     need_o
);

  always_comb begin
    need_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lane_i[i]) begin
        need_o.nAL = need_o.nAL + CNT_W'(1);
        if (!pkt_i[i].SkipIQ)
          need_o.nIQ = need_o.nIQ + CNT_W'(1);
        if (pkt_i[i].isLoad)
          need_o.nLd = need_o.nLd + CNT_W'(1);
        if (pkt_i[i].isStore)
          need_o.nSt = need_o.nSt + CNT_W'(1);
        need_o.ser = need_o.ser | pkt_i[i].isCSR |
                     pkt_i[i].isFenceI | pkt_i[i].isSret |
                     pkt_i[i].isMret;
      end
    end
  end

endmodule

// File: rtl/dispatch_bundle_receiver.sv
// In-order bundle queue between rename and dispatch; stall_o is flop-only.
// Optional same-cycle bypass when empty: DISPATCH_RX_BYPASS_EN.
module dispatch_bundle_receiver
  import dispatch_bundle_receiver_pkg::*;
#(
  parameter int DEPTH = DISPATCH_RX_DEPTH,
  parameter int WIDTH = DISPATCH_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush_i,
  dispatch_bundle_receiver_if.slave rx,
  input  logic [CNT_W-1:0]          iqFreeCnt_i,
  input  logic [CNT_W-1:0]          ldqFreeCnt_i,
  input  logic [CNT_W-1:0]          stqFreeCnt_i,
  input  logic [CNT_W-1:0]          alFreeCnt_i,
  input  logic                      backendStall_i,
  input  logic                      robEmpty_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CQ_W  = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CQ_W-1:0]  count_q, count_d;

  disPkt            pkt_q  [DEPTH][WIDTH];
  logic [WIDTH-1:0] lane_q [DEPTH];
  bundleNeeds_t     need_q [DEPTH];

  bundleNeeds_t in_need;
  bundleNeeds_t cur_need;
  head_st_e     head_st;
  logic         stall;
  logic         bypass;
  logic         fit;
  logic         fire;
  logic         enq;
  logic         deq;

  dispatch_need_count #(
    .WIDTH (WIDTH)
  ) u_need (
    .pkt_i  (rx.disPacket_i),
    .lane_i (rx.laneActive_i),
    .need_o (in_need)
  );

  assign stall      = (count_q == CQ_W'(DEPTH));
  assign rx.stall_o = stall;

  always_comb begin
    bypass   = 1'b0;
    cur_need = need_q[rd_ptr_q];
`ifdef DISPATCH_RX_BYPASS_EN
    if (count_q == '0 && rx.renameReady_i && !flush_i) begin
      bypass   = 1'b1;
      cur_need = in_need;
    end
`endif
    fit = needs_fit(cur_need, iqFreeCnt_i, ldqFreeCnt_i,
                    stqFreeCnt_i, alFreeCnt_i);

    // Serialization is judged before resources.
    head_st = HD_SEND;
    if (count_q == '0 && !bypass)
      head_st = HD_IDLE;
    else if (cur_need.ser && !robEmpty_i)
      head_st = HD_WAIT_SER;
    else if (backendStall_i || !fit)
      head_st = HD_WAIT_RES;

    fire = (head_st == HD_SEND) && !flush_i;
    deq  = fire && !bypass;
    enq  = rx.renameReady_i && !stall && !flush_i &&
           !(bypass && fire);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq)
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CQ_W'(enq) - CQ_W'(deq);
    end
  end

  always_comb begin
    rx.dispatchValid_o = fire;
    rx.disPacket_o     = pkt_q[rd_ptr_q];
    rx.laneValid_o     = lane_q[rd_ptr_q];
    if (bypass) begin
      rx.disPacket_o = rx.disPacket_i;
      rx.laneValid_o = rx.laneActive_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        lane_q[i] <= '0;
        need_q[i] <= '0;
        for (int j = 0; j < WIDTH; j++)
          pkt_q[i][j] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq) begin
        pkt_q[wr_ptr_q]  <= rx.disPacket_i;
        lane_q[wr_ptr_q] <= rx.laneActive_i;
        need_q[wr_ptr_q] <= in_need;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_bundle_receiver.sv
// Directed bench for dispatch_bundle_receiver (default build, DEPTH=2).
// Hand-computed expectations per cycle.
module tb_dispatch_bundle_receiver;
  import dispatch_bundle_receiver_pkg::*;

  localparam int W = DISPATCH_WIDTH;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush_i;
  logic [CNT_W-1:0] iq_free;
  logic [CNT_W-1:0] ld_free;
  logic [CNT_W-1:0] st_free;
  logic [CNT_W-1:0] al_free;
  logic             bk_stall;
  logic             rob_empty;

  int n_chk = 0;
  int n_err = 0;

  dispatch_bundle_receiver_if #(.WIDTH(W)) bus ();

  dispatch_bundle_receiver #(
    .DEPTH (2),
    .WIDTH (W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush_i        (flush_i),
    .rx             (bus),
    .iqFreeCnt_i    (iq_free),
    .ldqFreeCnt_i   (ld_free),
    .stqFreeCnt_i   (st_free),
    .alFreeCnt_i    (al_free),
    .backendStall_i (bk_stall),
    .robEmpty_i     (rob_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0]  base,
                     input logic [W-1:0] lanes,
                     input logic [W-1:0] ld,
                     input logic [W-1:0] st,
                     input logic [W-1:0] csr);
    for (int i = 0; i < W; i++) begin
      bus.disPacket_i[i]          = '0;
      bus.disPacket_i[i].pc       = base + 32'(4 * i);
      bus.disPacket_i[i].isLoad   = ld[i];
      bus.disPacket_i[i].isStore  = st[i];
      bus.disPacket_i[i].isCSR    = csr[i];
    end
    bus.laneActive_i  = lanes;
    bus.renameReady_i = 1'b1;
  endtask

  task automatic frees(input int v);
    iq_free = CNT_W'(v);
    ld_free = CNT_W'(v);
    st_free = CNT_W'(v);
    al_free = CNT_W'(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    flush_i   = 1'b0;
    bk_stall  = 1'b0;
    rob_empty = 1'b1;
    frees(8);
    bus.renameReady_i = 1'b0;
    bus.laneActive_i  = '0;
    for (int i = 0; i < W; i++) bus.disPacket_i[i] = '0;

    #2;
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_dv", bus.dispatchValid_o, 0);
    chk("rst_lane", bus.laneValid_o, 0);
    chk("rst_pc", bus.disPacket_o[0].pc, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // back-to-back, pointers wrap twice
    for (int k = 0; k < 5; k++) begin
      if (k < 4)
        put(32'h100 + 32'(16 * k), 4'hF, 4'b0001, 4'b0010, 4'b0000);
      else
        bus.renameReady_i = 1'b0;
      #1;
      if (k == 0) begin
        chk("b2b_dv_first", bus.dispatchValid_o, 0);
      end else begin
        chk("b2b_dv", bus.dispatchValid_o, 1);
        chk("b2b_pc", bus.disPacket_o[0].pc, 32'h100 + 32'(16 * (k - 1)));
      end
      chk("b2b_stall", bus.stall_o, 0);
      tick();
    end
    #1;
    chk("b2b_empty", bus.dispatchValid_o, 0);

    // resource block on load queue
    ld_free = CNT_W'(1);
    put(32'h200, 4'hF, 4'b0011, 4'b0000, 4'b0000);
    #1;
    chk("res_c0_dv", bus.dispatchValid_o, 0);
    tick();
    put(32'h300, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    #1;
    chk("res_c1_dv", bus.dispatchValid_o, 0);
    chk("res_c1_stall", bus.stall_o, 0);
    tick();
    bus.renameReady_i = 1'b0;
    #1;
    chk("res_c2_dv", bus.dispatchValid_o, 0);
    chk("res_c2_stall", bus.stall_o, 1);
    tick();
    ld_free = CNT_W'(2);
    #1;
    chk("res_c3_dv", bus.dispatchValid_o, 1);
    chk("res_c3_pc", bus.disPacket_o[0].pc, 32'h200);
    chk("res_c3_stall", bus.stall_o, 1);
    tick();
    #1;
    chk("res_c4_stall", bus.stall_o, 0);
    chk("res_c4_dv", bus.dispatchValid_o, 1);
    chk("res_c4_pc", bus.disPacket_o[0].pc, 32'h300);
    tick();
    #1;
    chk("res_c5_dv", bus.dispatchValid_o, 0);
    ld_free = CNT_W'(8);

    // serializing head waits for empty ROB
    rob_empty = 1'b0;
    put(32'h400, 4'hF, 4'b0000, 4'b0000, 4'b0010);
    #1;
    chk("ser_c0_dv", bus.dispatchValid_o, 0);
    tick();
    bus.renameReady_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("ser_wait_dv", bus.dispatchValid_o, 0);
      tick();
    end
    rob_empty = 1'b1;
    #1;
    chk("ser_go_dv", bus.dispatchValid_o, 1);
    chk("ser_go_pc", bus.disPacket_o[0].pc, 32'h400);
    tick();
    #1;
    chk("ser_after_dv", bus.dispatchValid_o, 0);

    // flush while full with a bundle presented
    bk_stall = 1'b1;
    put(32'h500, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    tick();
    put(32'h600, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    tick();
    put(32'h700, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    bk_stall = 1'b0;
    flush_i  = 1'b1;
    #1;
    chk("fl_full_stall", bus.stall_o, 1);
    chk("fl_full_dv", bus.dispatchValid_o, 0);
    tick();
    flush_i = 1'b0;
    bus.renameReady_i = 1'b0;
    #1;
    chk("fl_next_stall", bus.stall_o, 0);
    chk("fl_next_dv", bus.dispatchValid_o, 0);
    tick();

    // flush at count=1 discards the presented bundle too
    put(32'h800, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    tick();
    put(32'h900, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    flush_i = 1'b1;
    #1;
    chk("fl1_dv", bus.dispatchValid_o, 0);
    tick();
    flush_i = 1'b0;
    bus.renameReady_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fl1_drop_dv", bus.dispatchValid_o, 0);
      tick();
    end

    // inactive lanes contribute no needs
    st_free   = '0;
    rob_empty = 1'b0;
    put(32'hA00, 4'b0011, 4'b0000, 4'b1000, 4'b0100);
    #1;
    chk("lane_c0_dv", bus.dispatchValid_o, 0);
    tick();
    bus.renameReady_i = 1'b0;
    #1;
    chk("lane_dv", bus.dispatchValid_o, 1);
    chk("lane_valid", bus.laneValid_o, 4'b0011);
    chk("lane_pc", bus.disPacket_o[0].pc, 32'hA00);
    tick();
    rob_empty = 1'b1;
    st_free   = CNT_W'(8);

    // zero-lane bundle: only backendStall can hold it
    frees(0);
    bk_stall = 1'b1;
    put(32'hB00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    bus.renameReady_i = 1'b0;
    #1;
    chk("zero_held_dv", bus.dispatchValid_o, 0);
    bk_stall = 1'b0;
    #1;
    chk("zero_dv", bus.dispatchValid_o, 1);
    chk("zero_lane", bus.laneValid_o, 0);
    chk("zero_pc", bus.disPacket_o[0].pc, 32'hB00);
    tick();
    #1;
    chk("zero_after_dv", bus.dispatchValid_o, 0);
    frees(8);

    // asynchronous reset mid-stream at count=2
    bk_stall = 1'b1;
    put(32'hC00, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    tick();
    put(32'hD00, 4'hF, 4'b0000, 4'b0000, 4'b0000);
    tick();
    bus.renameReady_i = 1'b0;
    #1;
    chk("mrst_pre_stall", bus.stall_o, 1);
    reset_n = 1'b0;
    #1;
    chk("mrst_stall", bus.stall_o, 0);
    chk("mrst_dv", bus.dispatchValid_o, 0);
    tick();
    reset_n  = 1'b1;
    bk_stall = 1'b0;
    #1;
    chk("mrst_lane", bus.laneValid_o, 0);
    chk("mrst_pc", bus.disPacket_o[0].pc, 0);
    tick();
    #1;
    chk("mrst_empty_dv", bus.dispatchValid_o, 0);
    chk("mrst_empty_stall", bus.stall_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dispatch_bundle_receiver.md
# dispatch_bundle_receiver

- Receives rename→dispatch bundles (`disPkt` array plus `renameReady`) at the dispatch end of the rename/dispatch pipeline register.
- Buffers them in a small in-order bundle queue.
- Releases the head bundle to the issue queue, LSQ and active list only when all backend resources for every valid lane are available.
- Returns a flop-derived `stall_o` to the rename/dispatch register, which removes the combinational path from backend free-counts to frontend stall.

## Interface
- `DEPTH`, default 2: bundle queue entries (power of two, ≥2).
- `WIDTH`, default `` `DISPATCH_WIDTH ``: lanes per bundle.
- `clk`  in  1: core clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `flush_i`  in  1: pipeline flush.
- `renameReady_i`  in  1: incoming bundle valid.
- `disPacket_i`  in  `disPkt [WIDTH]`: incoming bundle.
- `laneActive_i`  in  WIDTH: lane enable; a lane is valid iff its bit is set.
- `iqFreeCnt_i`, `ldqFreeCnt_i`, `stqFreeCnt_i`, `alFreeCnt_i`  in  `CNT_W` each: backend free entries.
- `backendStall_i`  in  1: global dispatch hold.
- `robEmpty_i`  in  1: active list empty.
- `stall_o`  out  1: upstream backpressure.
- `dispatchValid_o`  out  1: head bundle released this cycle.
- `disPacket_o`  out  `disPkt [WIDTH]`: head bundle.
- `laneValid_o`  out  WIDTH: valid lanes of the head bundle.

## Operation
**Enqueue**
- Enqueue when `renameReady_i && !stall_o && !flush_i`.
- At enqueue, store the packet, `laneActive_i`, and precomputed needs:
  - `nIQ`: valid lanes with `SkipIQ`=0.
  - `nLd`: valid lanes with `isLoad`.
  - `nSt`: valid lanes with `isStore`.
  - `nAL`: valid lanes.
  - `ser`: OR over valid lanes of `isCSR | isFenceI | isSret | isMret`.
- `stall_o` = (count == DEPTH), decoded from the count flop only.

**Dispatch**
- Fit condition, with all comparisons unsigned at `CNT_W`: `nIQ ≤ iqFree && nLd ≤ ldqFree && nSt ≤ stqFree && nAL ≤ alFree`.
- `dispatchValid_o` = count>0 && !backendStall_i && fit && (!ser || robEmpty_i).
- On `dispatchValid_o`, head advances.
- A bundle is dispatched whole or not at all; there is no partial lane release.

**Head FSM** (per head bundle):
- IDLE (count=0).
- WAIT_RES (resources insufficient).
- WAIT_SER (`ser` set, ROB not empty).
- SEND.
- Priority: WAIT_SER is evaluated before resources.

**Boundaries**
- When full, enqueue is blocked even if a dispatch occurs the same cycle. This is a deliberate one-cycle bubble that keeps `stall_o` flop-only.
- Enqueue and dispatch in the same cycle when 0<count<DEPTH: count is unchanged.
- Pointers wrap modulo DEPTH.
- Flush clears count and pointers next edge, discards any bundle presented in the flush cycle, and forces `dispatchValid_o`=0 combinationally in the flush cycle.
- A bundle with zero valid lanes is still enqueued and dispatched: needs are 0, so it passes fit unless `backendStall_i` is set. It produces `laneValid_o`=0.

## Timing
- Reset (asynchronous, `reset_n` low):
  - count=0, pointers=0.
  - `stall_o`=0, `dispatchValid_o`=0.
  - `disPacket_o`=0 and `laneValid_o`=0 (storage cleared).
- Latency: bundle accepted at edge t is on `disPacket_o` in cycle t+1; earliest dispatch is cycle t+1.
- `stall_o` rises the cycle after the enqueue that fills the queue, and falls the cycle after the first dispatch from full.
- Sustained throughput is 1 bundle/cycle with DEPTH≥2 and resources available.

## Configuration
- Macro: `DISPATCH_RX_BYPASS_EN`.
- Defined: when count=0, `!flush_i`, and the incoming bundle fits (same rules, needs computed combinationally), the bundle is dispatched in the same cycle from `disPacket_i` without being written. Latency is 0. This adds a combinational path from `disPacket_i` to `dispatchValid_o`.
- Undefined: the bypass path is absent; behaviour is as above.

## Structure
- Shared package holds:
  - `DISPATCH_RX_DEPTH`.
  - `CNT_W` (= `$clog2(WIDTH+1)`, at least wide enough for the largest free count).
  - `typedef struct` `bundleNeeds_t {nIQ, nLd, nSt, nAL, ser}`.
- One sub-module, `dispatch_need_count`, is combinational: it takes (`disPkt[WIDTH]`, `laneActive`) and produces `bundleNeeds_t`. It is instantiated at enqueue, and additionally on the bypass path when enabled.

## Test plan
- **Reset:** with `reset_n` low mid-stream and count=2 → next cycle count=0, `stall_o`=0, `dispatchValid_o`=0.
- **Back-to-back:** 4 bundles on consecutive cycles, WIDTH=4, all resources=8 → 4 dispatches on cycles 1–4, `stall_o` never asserted.
- **Resource block:** head has 2 loads, `ldqFreeCnt_i`=1 for 3 cycles then 2 → head held, second bundle enqueued, `stall_o`=1, dispatch on the cycle `ldqFree`=2, `stall_o`=0 the following cycle.
- **Serializing:** head lane 1 `isCSR`, `robEmpty_i`=0 for 5 cycles → no dispatch; dispatch the cycle `robEmpty_i`=1.
- **Flush:** count=2 with `renameReady_i`=1 in the flush cycle → `dispatchValid_o`=0 that cycle, count=0 next cycle, the flush-cycle bundle is never dispatched.
- **Lanes:** `laneActive_i`=4'b0011 with `isStore` on lane 3 → `nSt`=0, `laneValid_o`=4'b0011, dispatches with `stqFreeCnt_i`=0.
